ssm_tile_sequencer: RTL and testbench
=====================================

SSM_TILE_SEQUENCER -- requirements
Module: ssm_tile_sequencer

Interface
REQ-001 SHALL have parameter N_TILE, default 64: state lanes per tile.
REQ-002 SHALL have parameter N_MAX, default 128: maximum state dimension per group.
REQ-003 SHALL have parameter MAX_OUT, default 4: maximum groups in flight (power of 2).
REQ-004 SHALL have parameter GW, default 8: group-ID width. Derived: NW=clog2(N_MAX+1), TW=clog2(ceil(N_MAX/N_TILE)).
REQ-005 SHALL have port clk, input, 1: the only clock.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have ports grp_valid_i (in, 1), grp_ready_o (out, 1), grp_ntotal_i (in, NW), grp_id_i (in, GW): group request channel.
REQ-008 SHALL have ports tile_valid_o (out, 1), tile_ready_i (in, 1), tile_idx_o (out, TW), tile_first_o (out, 1), tile_last_o (out, 1), tile_mask_o (out, N_TILE), tile_grp_id_o (out, GW): tile command channel to the SSM core.
REQ-009 SHALL have port done_valid_i, input, 1: y_final valid pulse from the SSM core.
REQ-010 SHALL have ports grp_done_o (out, 1), grp_done_id_o (out, GW), outstanding_o (out, clog2(MAX_OUT+1)), err_o (out, 1).

Function
REQ-011 SHALL implement FSM IDLE/ISSUE: IDLE->ISSUE on accepted group with ntotal>0; ISSUE->IDLE on handshake of the last tile.
REQ-012 SHALL drive grp_ready_o = (state==IDLE) && (outstanding_o < MAX_OUT); a group is accepted on grp_valid_i && grp_ready_o.
REQ-013 SHALL latch ntotal and id on acceptance and compute tile count T = ceil(ntotal/N_TILE).
REQ-014 SHALL assert tile_valid_o the cycle after acceptance (latency 1), with tile_idx_o = 0.
REQ-015 SHALL hold all tile_* outputs stable while tile_valid_o && !tile_ready_i.
REQ-016 SHALL increment tile_idx_o on each tile handshake, keeping tile_valid_o high until tile T-1 handshakes; no idle cycles between tiles while tile_ready_i is high.
REQ-017 SHALL set tile_first_o = (tile_idx_o==0) and tile_last_o = (tile_idx_o==T-1); for T=1 both are high.
REQ-018 SHALL set tile_mask_o bit t = (tile_idx_o*N_TILE + t < ntotal): full tiles all-ones, partial last tile low-bit ones.
REQ-019 SHALL treat ntotal > N_MAX as ntotal = N_MAX and set err_o.
REQ-020 SHALL accept an ntotal==0 group, issue no tiles, leave outstanding_o unchanged, push no ID, stay IDLE, and set err_o.
REQ-021 SHALL push grp_id into an ID FIFO of depth MAX_OUT on acceptance of a nonzero group, and increment outstanding_o.
REQ-022 SHALL, on done_valid_i with outstanding_o>0, pop the FIFO, pulse grp_done_o for 1 cycle with grp_done_id_o = popped ID, and decrement outstanding_o (registered output, latency 1).
REQ-023 SHALL leave outstanding_o unchanged on simultaneous accept and done_valid_i; the push and pop both occur.
REQ-024 SHALL ignore done_valid_i when outstanding_o==0 (no pulse) and set err_o.
REQ-025 SHALL make err_o sticky until reset.

Reset
REQ-026 SHALL, on rst assertion at any time including mid-group, asynchronously force state=IDLE, tile_valid_o=0, tile_idx_o=0, tile_first_o=0, tile_last_o=0, tile_mask_o=0, tile_grp_id_o=0, grp_done_o=0, grp_done_id_o=0, outstanding_o=0, err_o=0, and the FIFO empty.
REQ-027 SHALL drive grp_ready_o=0 while rst is high and go high the first cycle after release.

Structure
REQ-028 SHALL take DW, N_TILE and the latency constants from shared package ssm_pkg; the FSM state enum SHALL also live in ssm_pkg.
REQ-029 SHALL implement the ID FIFO as sub-module ssm_id_fifo (params DEPTH, W; push/pop/empty/full, wrap-around pointers).

Verification
REQ-030 SHALL cover: ntotal=128, N_TILE=64, tile_ready_i=1 -> 2 tiles on consecutive cycles, idx 0/1, first/last correct, mask all-ones, outstanding_o=1.
REQ-031 SHALL cover: ntotal=100 -> tile 1 mask = 36 low bits set; tile_ready_i low 3 cycles on tile 0 -> outputs stable throughout.
REQ-032 SHALL cover: 4 groups, IDs 0xA0..0xA3, with no done -> grp_ready_o=0 on the 5th; then done_valid_i -> grp_done_id_o=0xA0 and grp_ready_o returns high.
REQ-033 SHALL cover: accept and done_valid_i in the same cycle with outstanding_o=2 -> outstanding_o stays 2 and FIFO order is preserved across pointer wrap.
REQ-034 SHALL cover: ntotal=0, and done_valid_i with outstanding_o=0 -> err_o=1, no tiles issued, no grp_done_o pulse.
REQ-035 SHALL cover: rst pulsed while tile 1 is pending -> all outputs reach reset values immediately; a new group afterwards starts at idx 0.

Source files
------------

// File: rtl/ssm_pkg.sv
// Shared SSM constants, the sequencer FSM state type and a small sizing helper.
package ssm_pkg;
    localparam int DW         = 16;
    localparam int N_TILE_DEF = 64;
    localparam int TILE_LAT   = 1;
    localparam int DONE_LAT   = 1;

    typedef enum logic {S_IDLE, S_ISSUE} seq_state_e;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction
endpackage

// File: rtl/ssm_tile_sequencer_if.sv
// Group request, tile command and completion signals of the tile sequencer.
interface ssm_tile_sequencer_if #(
    parameter int N_TILE = 64,
    parameter int NW     = 8,
    parameter int TW     = 1,
    parameter int GW     = 8,
    parameter int OW     = 3
);
    logic              grp_valid_i;
    logic              grp_ready_o;
    logic [NW-1:0]     grp_ntotal_i;
    logic [GW-1:0]     grp_id_i;
    logic              tile_valid_o;
    logic              tile_ready_i;
    logic [TW-1:0]     tile_idx_o;
    logic              tile_first_o;
    logic              tile_last_o;
    logic [N_TILE-1:0] tile_mask_o;
    logic [GW-1:0]     tile_grp_id_o;
    logic              done_valid_i;
    logic              grp_done_o;
    logic [GW-1:0]     grp_done_id_o;
    logic [OW-1:0]     outstanding_o;
    logic              err_o;

    modport master (
        input  grp_valid_i, grp_ntotal_i, grp_id_i, tile_ready_i, done_valid_i,
        output grp_ready_o, tile_valid_o, tile_idx_o, tile_first_o, tile_last_o,
               tile_mask_o, tile_grp_id_o, grp_done_o, grp_done_id_o, outstanding_o, err_o
    );
    modport slave (
        output grp_valid_i, grp_ntotal_i, grp_id_i, tile_ready_i, done_valid_i,
        input  grp_ready_o, tile_valid_o, tile_idx_o, tile_first_o, tile_last_o,
               tile_mask_o, tile_grp_id_o, grp_done_o, grp_done_id_o, outstanding_o, err_o
    );
endinterface

// File: rtl/ssm_id_fifo.sv
// Group-ID FIFO with wrap-around pointers; push when full / pop when empty are dropped.
module ssm_id_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= nxt(wr_q);
            if (do_pop)  rd_q <= nxt(rd_q);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/ssm_tile_sequencer.sv
// Splits each accepted group into N_TILE-lane tile commands and tracks in-flight
// groups so that completions from the SSM core are reported with their group ID.
module ssm_tile_sequencer
    import ssm_pkg::*;
#(
    parameter int N_TILE  = N_TILE_DEF,
    parameter int N_MAX   = 128,
    parameter int MAX_OUT = 4,
    parameter int GW      = 8
) (
    input  logic                clk,
    input  logic                rst,
    ssm_tile_sequencer_if.master bus
);
    localparam int NW     = $clog2(N_MAX + 1);
    localparam int NT_MAX = (N_MAX + N_TILE - 1) / N_TILE;
    localparam int TW     = (NT_MAX > 1) ? $clog2(NT_MAX) : 1;
    localparam int OW     = $clog2(MAX_OUT + 1);

    seq_state_e    state_q, state_d;
    logic [TW-1:0] idx_q, last_q;
    logic [NW-1:0] ntot_q, nclamp;
    logic [GW-1:0] id_q, done_id_q, fifo_dout;
    logic [OW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d, done_q;
    logic          tvalid, accept, push, pop, hs, zero_grp, over_grp;
    logic          fifo_empty, fifo_full;

    assign over_grp = bus.grp_ntotal_i > NW'(N_MAX);
    assign zero_grp = (bus.grp_ntotal_i == '0);
    assign nclamp   = over_grp ? NW'(N_MAX) : bus.grp_ntotal_i;

    // Gated by rst so the upstream never sees ready while reset is held.
    assign bus.grp_ready_o = !rst && (state_q == S_IDLE) && !fifo_full;
    assign accept = bus.grp_valid_i && bus.grp_ready_o;
    assign push   = accept && !zero_grp;
    assign pop    = bus.done_valid_i && !fifo_empty;
    assign tvalid = (state_q == S_ISSUE);
    assign hs     = tvalid && bus.tile_ready_i;

    assign cnt_d = cnt_q + OW'(push) - OW'(pop);
    assign err_d = err_q || (accept && (zero_grp || over_grp)) || (bus.done_valid_i && fifo_empty);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (push) state_d = S_ISSUE;
            S_ISSUE: if (hs && idx_q == last_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q     <= '0;
            last_q    <= '0;
            ntot_q    <= '0;
            id_q      <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            err_q  <= err_d;
            done_q <= pop;
            if (pop) done_id_q <= fifo_dout;
            if (push) begin
                idx_q  <= '0;
                ntot_q <= nclamp;
                id_q   <= bus.grp_id_i;
                last_q <= TW'(ceil_div(int'(nclamp), N_TILE) - 1);
            end else if (hs && idx_q != last_q) begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    ssm_id_fifo #(.DEPTH(MAX_OUT), .W(GW)) u_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (bus.grp_id_i),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // Lanes past ntotal in the final tile are masked off.
    always_comb begin
        bus.tile_mask_o = '0;
        for (int t = 0; t < N_TILE; t++)
            bus.tile_mask_o[t] = tvalid && ((int'(idx_q) * N_TILE + t) < int'(ntot_q));
    end

    assign bus.tile_valid_o  = tvalid;
    assign bus.tile_idx_o    = idx_q;
    assign bus.tile_first_o  = tvalid && (idx_q == '0);
    assign bus.tile_last_o   = tvalid && (idx_q == last_q);
    assign bus.tile_grp_id_o = id_q;
    assign bus.grp_done_o    = done_q;
    assign bus.grp_done_id_o = done_id_q;
    assign bus.outstanding_o = cnt_q;
    assign bus.err_o         = err_q;
endmodule

// File: tb/tb_ssm_tile_sequencer.sv
// Scoreboard bench for ssm_tile_sequencer: expected tiles/done IDs are queued at
// acceptance and compared by a monitor when the DUT emits them.
module tb_ssm_tile_sequencer;
    localparam int N_TILE  = 64;
    localparam int N_MAX   = 128;
    localparam int MAX_OUT = 4;
    localparam int GW      = 8;
    localparam int NW      = $clog2(N_MAX + 1);
    localparam int TW      = 1;
    localparam int OW      = $clog2(MAX_OUT + 1);

    logic clk = 1'b0;
    logic rst = 1'b0;

    ssm_tile_sequencer_if #(.N_TILE(N_TILE), .NW(NW), .TW(TW), .GW(GW), .OW(OW)) bus ();

    ssm_tile_sequencer #(.N_TILE(N_TILE), .N_MAX(N_MAX), .MAX_OUT(MAX_OUT), .GW(GW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [TW-1:0]     idx;
        logic              first;
        logic              last;
        logic [N_TILE-1:0] mask;
        logic [GW-1:0]     id;
    } tile_t;

    tile_t          tq[$];
    logic [GW-1:0]  dq[$];
    int             n_chk = 0;
    int             n_pass = 0;
    tile_t          mon_e, mon_g;
    logic [GW-1:0]  mon_id;

    // Reference model of the tiles a group should produce.
    task automatic push_group(input int n, input logic [GW-1:0] id);
        int    nc, t;
        tile_t e;
        nc = (n > N_MAX) ? N_MAX : n;
        t  = (nc + N_TILE - 1) / N_TILE;
        for (int i = 0; i < t; i++) begin
            e.idx   = TW'(i);
            e.first = (i == 0);
            e.last  = (i == t - 1);
            e.id    = id;
            for (int b = 0; b < N_TILE; b++) e.mask[b] = (i * N_TILE + b) < nc;
            tq.push_back(e);
        end
        if (t > 0) dq.push_back(id);
    endtask

    task automatic send_group(input int n, input logic [GW-1:0] id);
        bit ok;
        ok = 0;
        @(posedge clk); #1;
        bus.grp_valid_i  = 1'b1;
        bus.grp_ntotal_i = NW'(n);
        bus.grp_id_i     = id;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (bus.grp_ready_o) begin
                push_group(n, id);
                ok = 1;
            end
            @(posedge clk); #1;
        end
        bus.grp_valid_i = 1'b0;
        if (!ok) begin
            n_chk++;
            $display("FAIL send_timeout id=%h got no grp_ready_o within 50 cycles", id);
        end
    endtask

    task automatic pulse_done;
        @(posedge clk); #1;
        bus.done_valid_i = 1'b1;
        @(posedge clk); #1;
        bus.done_valid_i = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.tile_valid_o && bus.tile_ready_i) begin
                n_chk++;
                mon_g.idx   = bus.tile_idx_o;
                mon_g.first = bus.tile_first_o;
                mon_g.last  = bus.tile_last_o;
                mon_g.mask  = bus.tile_mask_o;
                mon_g.id    = bus.tile_grp_id_o;
                if (tq.size() == 0) begin
                    $display("FAIL tile_unexpected got idx=%0d id=%h, none expected", mon_g.idx, mon_g.id);
                end else begin
                    mon_e = tq.pop_front();
                    if (mon_g !== mon_e)
                        $display("FAIL tile got idx=%0d f=%b l=%b id=%h mask=%h exp idx=%0d f=%b l=%b id=%h mask=%h",
                                 mon_g.idx, mon_g.first, mon_g.last, mon_g.id, mon_g.mask,
                                 mon_e.idx, mon_e.first, mon_e.last, mon_e.id, mon_e.mask);
                    else n_pass++;
                end
            end
            if (bus.grp_done_o) begin
                n_chk++;
                if (dq.size() == 0) begin
                    $display("FAIL done_unexpected got id=%h, none expected", bus.grp_done_id_o);
                end else begin
                    mon_id = dq.pop_front();
                    if (bus.grp_done_id_o !== mon_id)
                        $display("FAIL done_id got %h exp %h", bus.grp_done_id_o, mon_id);
                    else n_pass++;
                end
            end
        end
    end

    task automatic chk_zero(input string name);
        logic [127:0] v;
        v = 128'({bus.tile_valid_o, bus.tile_idx_o, bus.tile_first_o, bus.tile_last_o, bus.tile_mask_o,
                  bus.tile_grp_id_o, bus.grp_done_o, bus.grp_done_id_o, bus.outstanding_o, bus.err_o,
                  bus.grp_ready_o});
        n_chk++;
        if (v !== '0) $display("FAIL %s outputs got %h exp 0", name, v);
        else n_pass++;
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        #2 chk_zero("reset_state");
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (bus.grp_ready_o !== 1'b1) $display("FAIL ready_after_reset got %b exp 1", bus.grp_ready_o);
        else n_pass++;
    endtask

    task automatic test_two_tiles;
        bus.tile_ready_i = 1'b1;
        send_group(128, 8'h11);
        @(negedge clk);
        n_chk++;
        if ({bus.tile_valid_o, bus.tile_idx_o, bus.outstanding_o} !== {1'b1, 1'b0, 3'd1})
            $display("FAIL first_tile_latency got v=%b idx=%0d out=%0d exp v=1 idx=0 out=1",
                     bus.tile_valid_o, bus.tile_idx_o, bus.outstanding_o);
        else n_pass++;
        @(negedge clk); @(negedge clk);
        n_chk++;
        if (bus.tile_valid_o !== 1'b0) $display("FAIL two_tiles_end got valid=%b exp 0", bus.tile_valid_o);
        else n_pass++;
        pulse_done;
        @(negedge clk); @(negedge clk);
        n_chk++;
        if (bus.outstanding_o !== 3'd0) $display("FAIL two_tiles_drain got out=%0d exp 0", bus.outstanding_o);
        else n_pass++;
    endtask

    task automatic test_stall;
        bit ok;
        bus.tile_ready_i = 1'b0;
        send_group(100, 8'h22);
        ok = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if ({bus.tile_valid_o, bus.tile_idx_o, bus.tile_first_o, bus.tile_last_o,
                 bus.tile_mask_o, bus.tile_grp_id_o} !== {1'b1, 1'b0, 1'b1, 1'b0, {N_TILE{1'b1}}, 8'h22}) begin
                ok = 0;
                $display("FAIL stall_hold cycle %0d got v=%b idx=%0d f=%b l=%b id=%h mask=%h exp v=1 idx=0 f=1 l=0 id=22 mask=all-ones",
                         c, bus.tile_valid_o, bus.tile_idx_o, bus.tile_first_o, bus.tile_last_o,
                         bus.tile_grp_id_o, bus.tile_mask_o);
            end
        end
        n_chk++;
        if (ok) n_pass++;
        @(posedge clk); #1 bus.tile_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        pulse_done;
        @(negedge clk); @(negedge clk);
    endtask

    task automatic test_fill;
        for (int g = 0; g < 4; g++) send_group(64, 8'hA0 + 8'(g));
        @(negedge clk);
        n_chk++;
        if (bus.outstanding_o !== 3'd4) $display("FAIL fill_outstanding got %0d exp 4", bus.outstanding_o);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (bus.grp_ready_o !== 1'b0) $display("FAIL full_ready got %b exp 0", bus.grp_ready_o);
        else n_pass++;
        pulse_done;
        @(negedge clk);
        n_chk++;
        if (bus.grp_ready_o !== 1'b1) $display("FAIL ready_after_done got %b exp 1", bus.grp_ready_o);
        else n_pass++;
        send_group(64, 8'hA4);
    endtask

    task automatic test_simul;
        pulse_done;
        pulse_done;
        @(posedge clk); #1;
        bus.grp_valid_i  = 1'b1;
        bus.grp_ntotal_i = NW'(64);
        bus.grp_id_i     = 8'hB0;
        bus.done_valid_i = 1'b1;
        @(negedge clk);
        n_chk++;
        if (bus.grp_ready_o !== 1'b1 || bus.outstanding_o !== 3'd2)
            $display("FAIL simul_pre got ready=%b out=%0d exp ready=1 out=2", bus.grp_ready_o, bus.outstanding_o);
        else begin
            n_pass++;
            push_group(64, 8'hB0);
        end
        @(posedge clk); #1;
        bus.grp_valid_i  = 1'b0;
        bus.done_valid_i = 1'b0;
        @(negedge clk);
        n_chk++;
        if (bus.outstanding_o !== 3'd2) $display("FAIL simul_outstanding got %0d exp 2", bus.outstanding_o);
        else n_pass++;
        pulse_done;
        pulse_done;
        @(negedge clk); @(negedge clk);
        n_chk++;
        if (bus.outstanding_o !== 3'd0) $display("FAIL simul_drain got %0d exp 0", bus.outstanding_o);
        else n_pass++;
    endtask

    task automatic test_err;
        bit quiet;
        n_chk++;
        if (bus.err_o !== 1'b0) $display("FAIL err_clean got %b exp 0", bus.err_o);
        else n_pass++;
        send_group(0, 8'h55);
        @(negedge clk);
        n_chk++;
        if ({bus.err_o, bus.outstanding_o, bus.tile_valid_o} !== {1'b1, 3'd0, 1'b0})
            $display("FAIL zero_group got err=%b out=%0d v=%b exp err=1 out=0 v=0",
                     bus.err_o, bus.outstanding_o, bus.tile_valid_o);
        else n_pass++;
        quiet = 1;
        bus.done_valid_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.grp_done_o !== 1'b0 || bus.tile_valid_o !== 1'b0) quiet = 0;
        end
        bus.done_valid_i = 1'b0;
        @(negedge clk);
        n_chk++;
        if (!quiet || bus.grp_done_o !== 1'b0 || bus.err_o !== 1'b1)
            $display("FAIL spurious_done got quiet=%b err=%b exp quiet=1 err=1", quiet, bus.err_o);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        bus.tile_ready_i = 1'b0;
        send_group(128, 8'h66);
        bus.tile_ready_i = 1'b1;
        @(posedge clk); #1 bus.tile_ready_i = 1'b0;
        @(negedge clk); #2 rst = 1'b1;
        #1 chk_zero("reset_mid_group");
        tq.delete();
        dq.delete();
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({bus.grp_ready_o, bus.err_o, bus.tile_valid_o} !== 3'b100)
            $display("FAIL post_reset got ready=%b err=%b v=%b exp 1 0 0", bus.grp_ready_o, bus.err_o, bus.tile_valid_o);
        else n_pass++;
        bus.tile_ready_i = 1'b1;
        send_group(200, 8'h77);
        @(negedge clk);
        n_chk++;
        if (bus.err_o !== 1'b1) $display("FAIL over_ntotal_err got %b exp 1", bus.err_o);
        else n_pass++;
        repeat (3) @(posedge clk);
        pulse_done;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        bus.grp_valid_i  = 1'b0;
        bus.grp_ntotal_i = '0;
        bus.grp_id_i     = '0;
        bus.tile_ready_i = 1'b0;
        bus.done_valid_i = 1'b0;
        test_reset;
        test_two_tiles;
        test_stall;
        test_fill;
        test_simul;
        test_err;
        test_reset_mid;
        n_chk++;
        if (tq.size() != 0 || dq.size() != 0)
            $display("FAIL scoreboard_left got tiles=%0d dones=%0d exp 0 0", tq.size(), dq.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
